// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8 request/grant bundle.
// master = requesting side, slave = arbiter.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic       rel;
  logic       mode;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  modport master (
    output req, rel, mode,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, rel, mode,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: 8-way fixed/round-robin arbiter
// with owner release, request drop and hold limit.
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CW       = 8
) (
  input logic         clk,
  input logic         rst_n,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [7:0]    gnt_q, gnt_d;
  logic [2:0]    id_q, id_d;
  logic          vld_q, vld_d;
  logic [2:0]    last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          to_q, to_d;

  logic [2:0] fix_w;
  logic [2:0] rr_w;
  logic [2:0] win;
  logic [2:0] idx;
  logic       drop;
  logic       hold_hit;
  logic       rel_hit;

  // Winner candidates: highest index, and first
  // set bit above the previous owner (wrapping).
  always_comb begin
    fix_w = '0;
    for (int i = 0; i < 8; i++)
      if (bus.req[i]) fix_w = 3'(i);
    rr_w = '0;
    idx  = '0;
    for (int i = 7; i >= 0; i--) begin
      idx = last_q + 3'd1 + 3'(i);
      if (bus.req[idx]) rr_w = idx;
    end
    win = bus.mode ? rr_w : fix_w;
  end

  // Exit conditions while a grant is held.
  always_comb begin
    rel_hit  = bus.rel;
    drop     = ~bus.req[id_q];
    hold_hit = (cnt_q == CW'(MAX_HOLD - 1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    vld_d   = vld_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d = BUSY;
          gnt_d   = 8'd1 << win;
          id_d    = win;
          vld_d   = 1'b1;
          last_d  = win;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (rel_hit || drop || hold_hit) begin
          state_d = IDLE;
          gnt_d   = '0;
          vld_d   = 1'b0;
          cnt_d   = '0;
          to_d    = hold_hit & ~rel_hit & ~drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 3'd7;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = vld_q;
  assign bus.timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed checks of rr_arbiter8
// grant, gap, round-robin, hold limit and reset.
module tb_rr_arbiter8;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(
    .MAX_HOLD(16),
    .CW(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req  = '0;
    bus.rel  = 1'b0;
    bus.mode = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    do_reset();

    chk("rst_gnt", 32'(bus.gnt), 32'h0);
    chk("rst_vld", 32'(bus.gnt_valid), 32'h0);
    chk("rst_id", 32'(bus.gnt_id), 32'h0);
    chk("rst_to", 32'(bus.timeout), 32'h0);

    // fixed priority: highest index wins
    bus.req = 8'b0010_0100;
    cyc();
    chk("fix_gnt", 32'(bus.gnt), 32'h20);
    chk("fix_id", 32'(bus.gnt_id), 32'd5);
    chk("fix_vld", 32'(bus.gnt_valid), 32'h1);
    bus.rel = 1'b1;
    cyc();
    chk("fix_gap", 32'(bus.gnt), 32'h0);
    chk("fix_gapv", 32'(bus.gnt_valid), 32'h0);
    chk("fix_gapid", 32'(bus.gnt_id), 32'd5);
    bus.rel = 1'b0;
    cyc();
    chk("fix_regnt", 32'(bus.gnt), 32'h20);
    // other reqs and mode ignored while busy
    bus.req  = 8'b1010_0100;
    bus.mode = 1'b1;
    cyc();
    chk("busy_hold", 32'(bus.gnt), 32'h20);
    bus.req = 8'h0;
    cyc();
    chk("drop_gnt", 32'(bus.gnt), 32'h0);
    chk("drop_to", 32'(bus.timeout), 32'h0);
    // release in idle is ignored
    bus.rel = 1'b1;
    cyc();
    chk("idle_rel", 32'(bus.gnt_valid), 32'h0);
    chk("idle_id", 32'(bus.gnt_id), 32'd5);
    bus.rel = 1'b0;

    // round-robin from reset: 0..7 then 0
    do_reset();
    bus.mode = 1'b1;
    bus.req  = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      cyc();
      chk("rr_id", 32'(bus.gnt_id), 32'(k % 8));
      chk("rr_gnt", 32'(bus.gnt),
          32'h1 << (k % 8));
      bus.rel = 1'b1;
      cyc();
      chk("rr_gap", 32'(bus.gnt), 32'h0);
      bus.rel = 1'b0;
    end
    bus.req = 8'h0;
    cyc();
    chk("rr_idle", 32'(bus.gnt_valid), 32'h0);

    // wrap-around: last=6, req {7,0}
    bus.req = 8'h40;
    cyc();
    chk("wr_6", 32'(bus.gnt_id), 32'd6);
    bus.req = 8'b1000_0001;
    bus.rel = 1'b1;
    cyc();
    bus.rel = 1'b0;
    cyc();
    chk("wr_7", 32'(bus.gnt), 32'h80);
    bus.rel = 1'b1;
    cyc();
    bus.rel = 1'b0;
    cyc();
    chk("wr_0", 32'(bus.gnt), 32'h01);
    bus.rel = 1'b1;
    cyc();
    bus.rel = 1'b0;
    cyc();
    chk("wr_7b", 32'(bus.gnt), 32'h80);
    bus.req = 8'h0;
    cyc();
    chk("wr_end", 32'(bus.gnt), 32'h0);

    // hold limit: 16 cycles then timeout
    bus.mode = 1'b0;
    bus.req  = 8'h08;
    for (int i = 0; i < 16; i++) begin
      cyc();
      chk("hold_gnt", 32'(bus.gnt), 32'h08);
      chk("hold_to", 32'(bus.timeout), 32'h0);
    end
    cyc();
    chk("tmo_gnt", 32'(bus.gnt), 32'h0);
    chk("tmo_to", 32'(bus.timeout), 32'h1);
    cyc();
    chk("tmo_regnt", 32'(bus.gnt), 32'h08);
    chk("tmo_pulse", 32'(bus.timeout), 32'h0);

    // drop on same edge as hold limit
    for (int i = 0; i < 15; i++) cyc();
    chk("lim_gnt", 32'(bus.gnt), 32'h08);
    bus.req = 8'h0;
    cyc();
    chk("lim_gnt0", 32'(bus.gnt), 32'h0);
    chk("lim_to", 32'(bus.timeout), 32'h0);

    // release on same edge as hold limit
    bus.req = 8'h02;
    for (int i = 0; i < 16; i++) cyc();
    chk("rl_gnt", 32'(bus.gnt), 32'h02);
    bus.rel = 1'b1;
    cyc();
    bus.rel = 1'b0;
    chk("rl_gnt0", 32'(bus.gnt), 32'h0);
    chk("rl_to", 32'(bus.timeout), 32'h0);
    bus.req = 8'h0;
    cyc();

    // async reset mid-grant
    bus.req = 8'h10;
    cyc();
    chk("ar_gnt", 32'(bus.gnt), 32'h10);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_gnt0", 32'(bus.gnt), 32'h0);
    chk("ar_vld", 32'(bus.gnt_valid), 32'h0);
    chk("ar_id", 32'(bus.gnt_id), 32'h0);
    cyc();
    rst_n = 1'b1;
    bus.req = 8'h0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
